// File: rtl/clk_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : clk_freq_meter
//  Description : Multi-channel frequency meter; counts synchronised rising
//                edges of each input over a gate window of clk cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_freq_meter #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 24,
    parameter int GATE_CYCLES = 100000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    mode,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       sig_in,
    output logic [NUM_CH*CNT_W-1:0] freq_cnt,
    output logic [NUM_CH-1:0]       overflow,
    output logic                    freq_valid,
    output logic                    busy
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] c_gateLast = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_cntMax   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_stateNext;
    logic [GATE_W-1:0]         r_gateCnt;
    logic                      w_countEn;
    logic                      w_latch;
    logic [NUM_CH*CNT_W-1:0]   w_cntFlat;
    logic [NUM_CH-1:0]         w_ovfVec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable && (!mode || start)) begin
                    w_stateNext = S_RUN;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    w_stateNext = S_IDLE;
                end else if (r_gateCnt == c_gateLast) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                if (enable && !mode) begin
                    w_stateNext = S_RUN;
                end else begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Gate counter restarts from zero on every entry into RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gateCnt <= '0;
        end else if (r_state == S_RUN && w_stateNext == S_RUN) begin
            r_gateCnt <= r_gateCnt + GATE_W'(1);
        end else begin
            r_gateCnt <= '0;
        end
    end

    assign w_countEn = (r_state == S_RUN);
    assign w_latch   = (r_state == S_DONE) && enable;
    assign busy      = (r_state == S_RUN);

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic                   r_prev;
            logic [CNT_W-1:0]       r_edgeCnt;
            logic                   r_ovf;
            logic                   w_edge;

            assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

            // Outside RUN the counter is held clear, so IDLE/DONE edges are dropped.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync    <= '0;
                    r_prev    <= 1'b0;
                    r_edgeCnt <= '0;
                    r_ovf     <= 1'b0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in[i]};
                    r_prev <= r_sync[SYNC_STAGES-1];
                    if (!w_countEn) begin
                        r_edgeCnt <= '0;
                        r_ovf     <= 1'b0;
                    end else if (w_edge) begin
                        if (r_edgeCnt == c_cntMax) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_edgeCnt <= r_edgeCnt + CNT_W'(1);
                        end
                    end
                end
            end

            assign w_cntFlat[i*CNT_W +: CNT_W] = r_edgeCnt;
            assign w_ovfVec[i]                 = r_ovf;
        end
    endgenerate

    // Results move only alongside the freq_valid pulse, one cycle after DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freq_cnt   <= '0;
            overflow   <= '0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= w_latch;
            if (w_latch) begin
                freq_cnt <= w_cntFlat;
                overflow <= w_ovfVec;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_freq_meter
//  Description : Directed scoreboard bench for clk_freq_meter (24-bit and
//                8-bit counter builds, 1000-cycle gate, 100 MHz clock).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_freq_meter;

    localparam int NUM_CH = 4;
    localparam int GATE   = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, mode, start, enable8;
    logic [3:0]  sig, sig8;
    logic [95:0] freq_cnt;
    logic [3:0]  overflow;
    logic        freq_valid, busy;
    logic [31:0] cnt8;
    logic [3:0]  ovf8;
    logic        valid8, busy8;

    logic gen10 = 1'b0, gen25 = 1'b0, gen50 = 1'b0;
    logic manual0 = 1'b0, useManual = 1'b0, sel8fast = 1'b1;

    // Edge offsets keep the generated inputs away from the clk edges.
    initial begin #4; forever #50 gen10 = ~gen10; end
    initial begin #3; forever #20 gen25 = ~gen25; end
    initial begin #2; forever #10 gen50 = ~gen50; end

    assign sig  = {1'b0, gen50, gen25, useManual ? manual0 : gen10};
    assign sig8 = {3'b000, sel8fast ? gen50 : gen10};

    clk_freq_meter #(.NUM_CH(NUM_CH), .CNT_W(24), .GATE_CYCLES(GATE), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .start(start),
        .sig_in(sig), .freq_cnt(freq_cnt), .overflow(overflow),
        .freq_valid(freq_valid), .busy(busy)
    );

    clk_freq_meter #(.NUM_CH(NUM_CH), .CNT_W(8), .GATE_CYCLES(GATE), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(reset), .enable(enable8), .mode(1'b0), .start(1'b0),
        .sig_in(sig8), .freq_cnt(cnt8), .overflow(ovf8),
        .freq_valid(valid8), .busy(busy8)
    );

    typedef struct packed {
        logic [3:0][23:0] cnt;
        logic [3:0]       ovf;
        logic [3:0]       tol;
    } exp_t;

    exp_t q[$];
    exp_t q8[$];
    int   tests = 0, fails = 0;
    int   validCnt = 0, busyCnt = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input int a, input int b, input int c, input int d,
                                input logic [3:0] ov, input logic [3:0] tm);
        exp_t e;
        e.cnt[0] = 24'(a);
        e.cnt[1] = 24'(b);
        e.cnt[2] = 24'(c);
        e.cnt[3] = 24'(d);
        e.ovf    = ov;
        e.tol    = tm;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp, input int tol);
        logic ok;
        tests++;
        if (tol == 0) ok = (obs === exp);
        else          ok = ((obs + 64'(tol)) >= exp) && (obs <= (exp + 64'(tol)));
        assert (ok === 1'b1) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors: every result pulse pops one expected entry.
    always @(negedge clk) begin
        if (freq_valid) begin
            exp_t e;
            validCnt++;
            if (q.size() == 0) begin
                tests++;
                assert (q.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_valid: observed pending %0d, expected >0", q.size());
                end
            end else begin
                e = q.pop_front();
                for (int i = 0; i < NUM_CH; i++)
                    check($sformatf("cnt_ch%0d", i), 64'(freq_cnt[i*24 +: 24]), 64'(e.cnt[i]), e.tol[i] ? 1 : 0);
                check("ovf", 64'(overflow), 64'(e.ovf), 0);
            end
        end
        if (busy) busyCnt++;
    end

    always @(negedge clk) begin
        if (valid8) begin
            exp_t e;
            if (q8.size() == 0) begin
                tests++;
                assert (q8.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_valid8: observed pending %0d, expected >0", q8.size());
                end
            end else begin
                e = q8.pop_front();
                for (int i = 0; i < NUM_CH; i++)
                    check($sformatf("cnt8_ch%0d", i), 64'(cnt8[i*8 +: 8]), 64'(e.cnt[i]), e.tol[i] ? 1 : 0);
                check("ovf8", 64'(ovf8), 64'(e.ovf), 0);
            end
        end
    end

    task automatic drain(input int which, input int budget, input string tag);
        int n = 0;
        while (((which == 0) ? q.size() : q8.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        assert (((which == 0) ? q.size() : q8.size()) == 0) else begin
            fails++;
            $error("FAIL %s_drain: observed pending %0d, expected 0", tag,
                   (which == 0) ? q.size() : q8.size());
        end
    endtask

    task automatic waitHigh(input int sel, input int budget, input string tag);
        int n = 0;
        while (!((sel == 0) ? busy : freq_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        assert (((sel == 0) ? busy : freq_valid) === 1'b1) else begin
            fails++;
            $error("FAIL %s_wait: observed 0, expected 1 within %0d cycles", tag, budget);
        end
    endtask

    initial begin
        int v0, tBusy, tValid;
        reset = 1'b1; enable = 1'b0; mode = 1'b0; start = 1'b0; enable8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cnt",   freq_cnt,   0, 0);
        check("rst_ovf",   overflow,   0, 0);
        check("rst_valid", freq_valid, 0, 0);
        check("rst_busy",  busy,       0, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0, 0);

        // Continuous windows: first may be +/-1, later ones exact.
        q.push_back(mk(100, 250, 500, 0, 4'b0000, 4'b1111));
        q.push_back(mk(100, 250, 500, 0, 4'b0000, 4'b0000));
        q.push_back(mk(100, 250, 500, 0, 4'b0000, 4'b0000));
        enable = 1'b1;
        drain(0, 4000, "t1");
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("t1_idle_busy", busy, 0, 0);

        // Abort mid-window, results must hold.
        enable = 1'b1;
        waitHigh(0, 10, "t4_busy");
        repeat (500) @(negedge clk);
        v0 = validCnt;
        enable = 1'b0;
        @(negedge clk);
        check("t4_busy_drop", busy, 0, 0);
        repeat (1100) @(negedge clk);
        check("t4_no_valid", validCnt, v0, 0);
        check("t4_hold_ch0", freq_cnt[23:0],  100, 0);
        check("t4_hold_ch2", freq_cnt[71:48], 500, 0);
        q.push_back(mk(100, 250, 500, 0, 4'b0000, 4'b1111));
        enable = 1'b1;
        drain(0, 1500, "t4");

        // Asynchronous reset mid-window, then latency from RUN entry.
        repeat (300) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5_cnt0",   freq_cnt,   0, 0);
        check("t5_ovf0",   overflow,   0, 0);
        check("t5_busy0",  busy,       0, 0);
        check("t5_valid0", freq_valid, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        q.push_back(mk(100, 250, 500, 0, 4'b0000, 4'b1111));
        waitHigh(0, 10, "t5_busy");
        tBusy = cyc;
        waitHigh(1, 1100, "t5_valid");
        tValid = cyc;
        enable = 1'b0;
        check("t5_latency", tValid - tBusy, 1001, 0);
        drain(0, 5, "t5");

        // Single-shot with a second, ignored start.
        repeat (5) @(negedge clk);
        mode = 1'b1; enable = 1'b1;
        repeat (5) @(negedge clk);
        check("t3_no_start", busy, 0, 0);
        v0 = validCnt;
        busyCnt = 0;
        q.push_back(mk(100, 250, 500, 0, 4'b0000, 4'b1111));
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (200) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (1200) @(negedge clk);
        check("t3_busy_len", busyCnt, 1000, 0);
        check("t3_one_valid", validCnt - v0, 1, 0);
        check("t3_idle", busy, 0, 0);
        drain(0, 1, "t3");

        // Window boundaries: a high at negedge c is seen in RUN cycle c.
        useManual = 1'b1; manual0 = 1'b0;
        repeat (5) @(negedge clk);
        q.push_back(mk(2, 250, 500, 0, 4'b0000, 4'b0110));
        for (int c = 0; c < 1010; c++) begin
            @(negedge clk);
            manual0 = (c == 0) || (c == 999);
            start   = (c == 1);
        end
        drain(0, 5, "t6a");
        q.push_back(mk(1, 250, 500, 0, 4'b0000, 4'b0110));
        for (int c = 0; c < 1010; c++) begin
            @(negedge clk);
            manual0 = (c == 998) || (c == 1000);
            start   = (c == 1);
        end
        drain(0, 5, "t6b");
        enable = 1'b0; mode = 1'b0; start = 1'b0;

        // 8-bit build: saturation, then a clean window.
        sel8fast = 1'b1;
        q8.push_back(mk(255, 0, 0, 0, 4'b0001, 4'b0000));
        enable8 = 1'b1;
        drain(1, 1200, "t2a");
        enable8 = 1'b0;
        repeat (5) @(negedge clk);
        sel8fast = 1'b0;
        q8.push_back(mk(100, 0, 0, 0, 4'b0000, 4'b0001));
        q8.push_back(mk(100, 0, 0, 0, 4'b0000, 4'b0000));
        enable8 = 1'b1;
        drain(1, 2200, "t2b");
        enable8 = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
